// File: rtl/cmp_pkg.sv
// Shared types and helpers for the magnitude comparator and its per-bit slices.
package cmp_pkg;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } cmp_res_t;

   // Cascade encodings as {gt, lt}; unused cascade inputs tie to CASC_NONE.
   localparam logic [1:0] CASC_NONE = 2'b00;
   localparam logic [1:0] CASC_GT   = 2'b10;
   localparam logic [1:0] CASC_LT   = 2'b01;

   function automatic cmp_res_t make_res(input logic gt, input logic lt);
      cmp_res_t r;
      r.gt = gt;
      r.lt = lt & ~gt;
      r.eq = ~gt & ~lt;
      return r;
   endfunction

endpackage

// File: rtl/one_bit_cmp_slice.sv
// Combinational one-bit compare slice; a decision from a more-significant slice
// passes through unchanged, greater winning if both arrive.
module one_bit_cmp_slice (
   input  logic a_i,
   input  logic b_i,
   input  logic gt_i,
   input  logic lt_i,
   output logic gt_o,
   output logic lt_o
);

   assign gt_o = gt_i | (~lt_i & a_i & ~b_i);
   assign lt_o = ~gt_i & (lt_i | (~a_i & b_i));

endmodule

// File: rtl/one_bit_comparator.sv
// Registered magnitude comparator built from a chain of one-bit slices with
// cascade inputs, optional two's complement compare and a valid flag.
module one_bit_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             casc_gt_in,
   input  logic             casc_lt_in,
   output logic             out_valid,
   output logic             c,
   output logic             d,
   output logic             e,
   output logic             f
);

   logic [WIDTH:0] gt_chain;
   logic [WIDTH:0] lt_chain;
   cmp_res_t       res;

   assign gt_chain[WIDTH] = casc_gt_in;
   assign lt_chain[WIDTH] = casc_lt_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      logic a_bit;
      logic b_bit;
      // A set sign bit means the smaller value, so the MSB slice sees a and b swapped.
      if (SIGNED && (i == WIDTH - 1)) begin : g_sign
         assign a_bit = b[i];
         assign b_bit = a[i];
      end else begin : g_plain
         assign a_bit = a[i];
         assign b_bit = b[i];
      end

      one_bit_cmp_slice u_slice (
         .a_i  (a_bit),
         .b_i  (b_bit),
         .gt_i (gt_chain[i+1]),
         .lt_i (lt_chain[i+1]),
         .gt_o (gt_chain[i]),
         .lt_o (lt_chain[i])
      );
   end

   assign res = make_res(gt_chain[0], lt_chain[0]);

   logic     valid_q, valid_d;
   cmp_res_t flags_q, flags_d;
   logic     ne_q, ne_d;

   always_comb begin
      valid_d = in_valid;
      flags_d = flags_q;
      ne_d    = ne_q;
      if (in_valid) begin
         flags_d = res;
         ne_d    = ~res.eq;
      end
   end

   // Reset clears every flag, so d=0 after reset reads as "no result", not "unequal".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         flags_q <= '0;
         ne_q    <= 1'b0;
      end else begin
         valid_q <= valid_d;
         flags_q <= flags_d;
         ne_q    <= ne_d;
      end
   end

   assign out_valid = valid_q;
   assign c         = flags_q.gt;
   assign d         = flags_q.eq;
   assign e         = flags_q.lt;
   assign f         = ne_q;

endmodule

// File: tb/tb_one_bit_comparator.sv
// Self-checking bench: one-bit unsigned, four-bit unsigned and four-bit signed
// comparators driven together against a behavioural model and constant tables.
module tb_one_bit_comparator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, in_valid, casc_gt, casc_lt;
   logic       a1, b1;
   logic [3:0] a4, b4;

   logic v1, c1, d1, e1, f1;
   logic vu, cu, du, eu, fu;
   logic vs, cs, ds, es, fs;

   one_bit_comparator u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
      .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
      .out_valid(v1), .c(c1), .d(d1), .e(e1), .f(f1)
   );

   one_bit_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_dut_u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
      .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
      .out_valid(vu), .c(cu), .d(du), .e(eu), .f(fu)
   );

   one_bit_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4),
      .casc_gt_in(casc_gt), .casc_lt_in(casc_lt),
      .out_valid(vs), .c(cs), .d(ds), .e(es), .f(fs)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // expected {valid, c, d, e, f} per instance
   logic [4:0] exp1, expu, exps;

   function automatic logic [3:0] ref_flags(input int av, input int bv,
                                            input logic gi, input logic li);
      if (gi)           return 4'b1001;
      else if (li)      return 4'b0011;
      else if (av > bv) return 4'b1001;
      else if (av == bv) return 4'b0100;
      else              return 4'b0011;
   endfunction

   function automatic int sval4(input logic [3:0] x);
      return x[3] ? int'(x) - 16 : int'(x);
   endfunction

   function automatic logic [4:0] next_exp(input logic [4:0] cur, input logic [3:0] flags);
      if (!rst_n)        return 5'b0;
      else if (in_valid) return {1'b1, flags};
      else               return {1'b0, cur[3:0]};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: v/c/d/e/f got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   // Advance one clock edge, update the model and compare all three instances.
   task automatic step();
      logic [4:0] n1, nu, ns;
      n1 = next_exp(exp1, ref_flags(int'(a1), int'(b1), casc_gt, casc_lt));
      nu = next_exp(expu, ref_flags(int'(a4), int'(b4), casc_gt, casc_lt));
      ns = next_exp(exps, ref_flags(sval4(a4), sval4(b4), casc_gt, casc_lt));
      @(posedge clk);
      #1;
      exp1 = n1; expu = nu; exps = ns;
      check("model_w1u", {v1, c1, d1, e1, f1}, exp1);
      check("model_w4u", {vu, cu, du, eu, fu}, expu);
      check("model_w4s", {vs, cs, ds, es, fs}, exps);
   endtask

   typedef struct {
      logic       a, b, gi, li;
      logic [3:0] cdef;
   } vec_t;

   vec_t tbl[8];

   initial begin
      exp1 = '0; expu = '0; exps = '0;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1001};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1001};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0011};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b1001};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0011};

      // reset held with valid operands present
      rst_n = 1'b0; in_valid = 1'b1; casc_gt = 1'b0; casc_lt = 1'b0;
      a1 = 1'b1; b1 = 1'b0; a4 = 4'h9; b4 = 4'h2;
      step();
      step();
      check("reset_w1", {v1, c1, d1, e1, f1}, 5'b00000);
      check("reset_w4s", {vs, cs, ds, es, fs}, 5'b00000);
      rst_n = 1'b1;
      step();
      check("release_w1", {v1, c1, d1, e1, f1}, 5'b11001);

      // table sweep: plain compares and cascade precedence
      for (int i = 0; i < 8; i++) begin
         a1 = tbl[i].a; b1 = tbl[i].b; casc_gt = tbl[i].gi; casc_lt = tbl[i].li;
         a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
         step();
         check($sformatf("table_%0d", i), {v1, c1, d1, e1, f1}, {1'b1, tbl[i].cdef});
      end
      casc_gt = 1'b0; casc_lt = 1'b0;

      // hold: flags keep last result while in_valid is low
      a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1;
      step();
      check("hold_w1", {v1, c1, d1, e1, f1}, 5'b01001);
      in_valid = 1'b1;

      // signed four-bit boundaries
      a4 = 4'hF; b4 = 4'h1;
      step();
      check("signed_m1_lt_1", {vs, cs, ds, es, fs}, 5'b10011);
      check("unsigned_15_gt_1", {vu, cu, du, eu, fu}, 5'b11001);
      a4 = 4'h7; b4 = 4'h8;
      step();
      check("signed_7_gt_m8", {vs, cs, ds, es, fs}, 5'b11001);
      check("unsigned_7_lt_8", {vu, cu, du, eu, fu}, 5'b10011);
      a4 = 4'h8; b4 = 4'h8;
      step();
      check("signed_eq", {vs, cs, ds, es, fs}, 5'b10100);

      // reset in the middle of a toggling stream
      b1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a1 = i[1];
         rst_n = (i != 5);
         step();
         if (i == 5) check("midreset_w1", {v1, c1, d1, e1, f1}, 5'b00000);
         if (i == 6) check("after_midreset_w1", {v1, c1, d1, e1, f1}, {1'b1, a1 ? 4'b1001 : 4'b0100});
      end
      rst_n = 1'b1;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         rst_n    = ($urandom_range(0, 49) != 0);
         a1 = 1'($urandom); b1 = 1'($urandom);
         a4 = 4'($urandom); b4 = 4'($urandom);
         if ($urandom_range(0, 2) == 0) a4 = b4;
         casc_gt = ($urandom_range(0, 7) == 0);
         casc_lt = ($urandom_range(0, 7) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/one_bit_comparator.md
Name: one_bit_comparator

Overview:
- Registered magnitude comparator: compares operand a against operand b and reports greater, equal, less and not-equal flags.
- Default configuration (WIDTH=1) is the classic one-bit comparator; a wider WIDTH generalises it.
- Cascade inputs allow several instances to be chained MSB-slice to LSB-slice.
- Sits as a leaf arithmetic block feeding control/decision logic.

Parameters:
- WIDTH, 1, operand width in bits (>=1).
- SIGNED, 0, 1 = operands compared as two's complement; 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operands and cascade inputs valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- casc_gt_in  input  1  greater result from more-significant slice; tie 0 when unused.
- casc_lt_in  input  1  less result from more-significant slice; tie 0 when unused.
- out_valid  output  1  registered flags valid.
- c  output  1  greater: A > B.
- d  output  1  equal: A == B.
- e  output  1  less: A < B.
- f  output  1  not equal: A != B.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Reset: on a rising edge with rst_n=0, c, d, e, f and out_valid all become 0. Reset has priority over in_valid, including mid-stream; there is no partial result.
- When in_valid=1 at an edge, out_valid is set to 1 and the flags are loaded.
- When in_valid=0, out_valid is set to 0 and the flags hold their previous values.
- Local compare:
  - SIGNED=0: unsigned magnitude.
  - SIGNED=1: MSB is the sign bit. For WIDTH=1, value 1 means -1, so 1 < 0.
- Cascade precedence:
  - casc_gt_in=1 forces c=1, d=0, e=0, f=1.
  - Otherwise casc_lt_in=1 forces c=0, d=0, e=1, f=1.
  - Otherwise the local compare decides.
- Both cascade inputs asserted together is illegal; the block resolves it as greater (casc_gt_in wins).
- Invariants on every valid output:
  - Exactly one of c, d, e is 1.
  - f == ~d.
  - For WIDTH=1 unsigned: c = a&~b, d = ~(a^b), e = ~a&b, f = a^b.
- No combinational path from inputs to outputs.
- out_valid flags are idle-safe: after reset, d=0, meaning "no valid result", not "unequal".

Decomposition:
- Shared package cmp_pkg holds:
  - typedef cmp_res_t: struct {gt, eq, lt}.
  - Localparam encodings for cascade tie-off (CASC_NONE = gt0/lt0).
- Sub-module: one_bit_cmp_slice. A purely combinational per-bit slice that takes a_i, b_i and incoming gt/lt and produces gt/lt.
- The top instantiates WIDTH slices MSB-to-LSB in a generate loop. A SIGNED fix-up on the MSB slice swaps the roles of a and b.
- The top adds the valid pipeline register and output flops.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=0 -> c=d=e=f=0 and out_valid=0. Release -> next cycle c=1, d=0, e=0, f=1.
- Exhaustive WIDTH=1 unsigned sweep, in_valid=1, one cycle later each:
  - (a,b)=(0,0) -> c0 d1 e0 f0.
  - (0,1) -> c0 d0 e1 f1.
  - (1,0) -> c1 d0 e0 f1.
  - (1,1) -> c0 d1 e0 f0.
- Hold: apply a=1, b=0 valid, then in_valid=0 with a=0, b=1 -> out_valid drops to 0 and c stays 1.
- Cascade: casc_gt_in=1, a=0, b=1 -> c=1, e=0. Then casc_lt_in=1, a=1, b=0 -> e=1, c=0. Both asserted -> c=1.
- SIGNED=1, WIDTH=4: a=4'hF (-1), b=4'h1 -> e=1, f=1. Then a=4'h7, b=4'h8 -> c=1.
- Reset mid-stream: while toggling a every 2 cycles, assert rst_n=0 for 1 cycle -> outputs 0 on that edge. Correct results resume one cycle after release.
